// File: rtl/imem_loader_pkg.sv
// rtl/imem_loader_pkg.sv - shared types and constants for the instruction-memory loader
package imem_loader_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    HDR  = 3'd1,
    LOAD = 3'd2,
    CHK  = 3'd3,
    DONE = 3'd4,
    ERR  = 3'd5
  } state_e;

  localparam int HDR_BYTES = 4;
  localparam int CSUM_W    = 8;

  function automatic logic [CSUM_W-1:0] csum_add(input logic [CSUM_W-1:0] acc,
                                                 input logic [7:0]        b);
    return acc + CSUM_W'(b);
  endfunction

endpackage

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - streams a length-prefixed, checksummed image into instruction memory
// and keeps the processor held until the image has been fully written and verified.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int MEM_BYTES = 1024,
  parameter int ADDR_W    = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              cpu_hold,
  output logic              done,
  output logic              error
);

  localparam int CNT_W = $clog2(MEM_BYTES + 1);

  state_e              state_q, state_d;
  logic [31:0]         len_q, len_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [CSUM_W-1:0]   sum_q, sum_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [7:0]          wdata_q, wdata_d;
  logic [31:0]         len_next;
  logic                beat;

  // Handshake and status outputs are pure decodes of the state register.
  assign in_ready  = (state_q == HDR) || (state_q == LOAD) || (state_q == CHK);
  assign cpu_hold  = (state_q != DONE);
  assign done      = (state_q == DONE);
  assign error     = (state_q == ERR);
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;

  assign beat     = in_valid & in_ready;
  assign len_next = {len_q[23:0], in_data};

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    case (state_q)
      IDLE, DONE, ERR: begin
        if (start) begin
          state_d = HDR;
          len_d   = '0;
          cnt_d   = '0;
          sum_d   = '0;
        end
      end
      HDR: begin
        if (beat) begin
          len_d = len_next;
          if (cnt_q == CNT_W'(HDR_BYTES - 1)) begin
            cnt_d = '0;
            if (len_next > 32'(MEM_BYTES)) begin
              state_d = ERR;
            end else if (len_next == 32'd0) begin
              state_d = CHK;
            end else begin
              state_d = LOAD;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      LOAD: begin
        if (beat) begin
          sum_d   = csum_add(sum_q, in_data);
          we_d    = 1'b1;
          addr_d  = ADDR_W'(cnt_q);
          wdata_d = in_data;
          cnt_d   = cnt_q + CNT_W'(1);
          if ((32'(cnt_q) + 32'd1) == len_q) begin
            state_d = CHK;
          end
        end
      end
      CHK: begin
        if (beat) begin
          state_d = (CSUM_W'(in_data) == sum_q) ? DONE : ERR;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      len_q   <= '0;
      cnt_q   <= '0;
      sum_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - randomized scoreboard bench for imem_loader
module tb_imem_loader;

  localparam int MEM_BYTES = 1024;
  localparam int ADDR_W    = 32;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic              in_valid = 1'b0;
  logic [7:0]        in_data = 8'h00;
  logic              in_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;
  logic              cpu_hold;
  logic              done;
  logic              error;

  imem_loader #(.MEM_BYTES(MEM_BYTES), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .cpu_hold(cpu_hold), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int exp_addr_q[$];
  int exp_data_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every write strobe must match the oldest outstanding expected write.
  always @(negedge clk) begin
    if (mem_we !== 1'b0) begin
      if (exp_addr_q.size() == 0) begin
        check("unexpected_strobe", {31'd0, mem_we}, 32'd0);
      end else begin
        check("wr_addr", mem_addr, exp_addr_q.pop_front());
        check("wr_data", {24'd0, mem_wdata}, exp_data_q.pop_front());
      end
    end
  end

  task automatic do_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    check("start_in_ready", {31'd0, in_ready}, 32'd1);
    check("start_hold", {31'd0, cpu_hold}, 32'd1);
    check("start_done", {31'd0, done}, 32'd0);
    check("start_error", {31'd0, error}, 32'd0);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit is_pl, input int addr,
                           input int gap, output bit ok);
    int t;
    ok = 1'b0;
    for (int g = 0; g < gap; g++) begin
      @(negedge clk); in_valid = 1'b0;
    end
    @(negedge clk); in_valid = 1'b1; in_data = b;
    t = 0;
    while (!in_ready && t < 50) begin
      @(negedge clk); t++;
    end
    if (!in_ready) begin
      check("in_ready_timeout", 32'd0, 32'd1);
      in_valid = 1'b0;
    end else begin
      if (is_pl) begin
        exp_addr_q.push_back(addr);
        exp_data_q.push_back(int'(b));
      end
      @(posedge clk);
      ok = 1'b1;
    end
  endtask

  // mode: 0 = no gaps, 1 = valid toggles every cycle, 2 = random gaps.
  // abort_after >= 0 stops after that many payload bytes without checking the result.
  task automatic run_frame(input logic [31:0] len, input logic [7:0] pl[$],
                           input logic [7:0] csum, input int mode, input int abort_after);
    logic [7:0] bytes[$];
    bit         exp_err;
    int         sum;
    int         n_send;
    int         t;
    bit         ok;
    int         gap;
    sum = 0;
    foreach (pl[i]) sum = (sum + int'(pl[i])) % 256;
    exp_err = (len > MEM_BYTES) || (sum != int'(csum));
    for (int i = 0; i < 4; i++) bytes.push_back(len[31-8*i -: 8]);
    if (len <= MEM_BYTES) begin
      foreach (pl[i]) bytes.push_back(pl[i]);
      bytes.push_back(csum);
    end
    n_send = (abort_after >= 0) ? 4 + abort_after : bytes.size();
    do_start();
    for (int i = 0; i < n_send; i++) begin
      gap = (mode == 1 && i > 0) ? 1 : (mode == 2) ? int'($urandom_range(0, 2)) : 0;
      send_byte(bytes[i], (i >= 4) && (i < 4 + int'(len)), i - 4, gap, ok);
      if (!ok) break;
    end
    if (abort_after >= 0) return;
    @(negedge clk); in_valid = 1'b0;
    t = 0;
    while (!(done || error) && t < 20) begin
      @(negedge clk); t++;
    end
    check("frame_done", {31'd0, done}, {31'd0, !exp_err});
    check("frame_error", {31'd0, error}, {31'd0, exp_err});
    check("frame_hold", {31'd0, cpu_hold}, {31'd0, exp_err});
    check("frame_in_ready", {31'd0, in_ready}, 32'd0);
    repeat (2) @(negedge clk);
    check("pending_writes", exp_addr_q.size(), 32'd0);
  endtask

  logic [7:0]  pl[$];
  logic [31:0] rlen;
  int          rsum;
  logic [7:0]  rcs;

  initial begin
    repeat (2) @(negedge clk);
    rst = 1'b0;
    // 1: idle after reset
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (i == 0 || i == 9) begin
        check("idle_hold", {31'd0, cpu_hold}, 32'd1);
        check("idle_in_ready", {31'd0, in_ready}, 32'd0);
        check("idle_done", {31'd0, done}, 32'd0);
        check("idle_error", {31'd0, error}, 32'd0);
        check("idle_addr", mem_addr, 32'd0);
      end
    end
    // 2 and 3: reference frame, back-to-back and with valid toggling
    pl = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
    run_frame(32'd4, pl, 8'h0E, 0, -1);
    run_frame(32'd4, pl, 8'h0E, 1, -1);
    // 4: oversize length
    pl.delete();
    run_frame(32'd1025, pl, 8'h00, 0, -1);
    // 5: bad checksum then recovery
    pl = '{8'h01, 8'h02};
    run_frame(32'd2, pl, 8'h04, 0, -1);
    run_frame(32'd2, pl, 8'h03, 2, -1);
    // 6: reset mid-load, then empty image
    pl = '{8'h11, 8'h22, 8'h33, 8'h44};
    run_frame(32'd4, pl, 8'hAA, 0, 2);
    @(negedge clk); in_valid = 1'b0; rst = 1'b1; start = 1'b1;
    @(negedge clk); rst = 1'b0; start = 1'b0;
    check("rst_in_ready", {31'd0, in_ready}, 32'd0);
    check("rst_hold", {31'd0, cpu_hold}, 32'd1);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_error", {31'd0, error}, 32'd0);
    check("rst_pending", exp_addr_q.size(), 32'd0);
    repeat (5) @(negedge clk);
    pl.delete();
    run_frame(32'd0, pl, 8'h00, 0, -1);
    // largest legal image
    pl.delete(); rsum = 0;
    for (int i = 0; i < MEM_BYTES; i++) begin
      pl.push_back(8'($urandom));
      rsum = (rsum + int'(pl[i])) % 256;
    end
    run_frame(32'(MEM_BYTES), pl, 8'(rsum), 0, -1);
    // random frames, some with a corrupted checksum
    for (int f = 0; f < 10; f++) begin
      pl.delete(); rsum = 0;
      rlen = 32'($urandom_range(0, 24));
      for (int i = 0; i < int'(rlen); i++) begin
        pl.push_back(8'($urandom));
        rsum = (rsum + int'(pl[i])) % 256;
      end
      rcs = ($urandom_range(0, 3) == 0) ? 8'(rsum + int'($urandom_range(1, 255))) : 8'(rsum);
      run_frame(rlen, pl, rcs, 2, -1);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
